// File: rtl/spy_chain_sensor.sv
// Delay-chain sensor: launches an edge into an inverter chain, captures taps one clk later,
// decodes the thermometer pattern, and accumulates depth over 2^ACC_LOG2 launches.
// Optional build macro: SPY_BUBBLE_FILTER_EN (popcount decode, bubbles tolerated).

module singlepath_1_spy_p1n (
    input  logic a,
    input  logic s0,
    input  logic s1,
    input  logic s2,
    input  logic s3,
    output logic y
);
    assign y = ~((a & s2) | s0) ^ (s1 & s3);
endmodule

module spy_chain_sensor #(
    parameter int STAGES        = 50,
    parameter int SETTLE_CYCLES = 4,
    parameter int ACC_LOG2      = 4,
    localparam int TAP_W        = $clog2(STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [TAP_W-1:0]          depth,
    output logic [TAP_W+ACC_LOG2-1:0] depth_sum,
    output logic                      error
);
    localparam int SUM_W    = TAP_W + ACC_LOG2;
    localparam int SCW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CNT_W    = ACC_LOG2 + 1;
    localparam int LAUNCHES = 1 << ACC_LOG2;

    typedef enum logic [2:0] {IDLE, SETTLE, LAUNCH, CAPTURE, SYNC, ACCUM, DONE} stateT;

    stateT              state;
    logic               launch;
    logic [SCW-1:0]     settleCnt;
    logic [CNT_W-1:0]   sampleCnt;
    (* keep = 1 *) logic [STAGES-1:0] taps;
    (* keep = 1 *) logic [STAGES-1:0] tapA;
    (* keep = 1 *) logic [STAGES-1:0] tapB;
    logic [STAGES-1:0]  expVec;
    logic [STAGES-1:0]  nVec;
    logic [TAP_W-1:0]   encDepth;
    logic               bubble;

    // Each stage owns its output net so the chain is a plain feed-forward path.
    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : gStage
            (* keep = 1 *) logic y;
            logic a;
            if (g == 0) begin : gHead
                assign a = launch;
            end else begin : gBody
                assign a = gStage[g-1].y;
            end
            singlepath_1_spy_p1n uCell (
                .a (a),
                .s0(1'b0),
                .s1(1'b0),
                .s2(1'b1),
                .s3(1'b0),
                .y (y)
            );
            assign taps[g] = y;
        end
    endgenerate

    // A settled chain alternates polarity: stage 0 is ~launch, stage 1 is launch, ...
    always_comb begin
        expVec = '0;
        for (int k = 0; k < STAGES; k++) expVec[k] = launch ^ (k % 2 == 0);
    end
    assign nVec = ~(tapB ^ expVec);

`ifdef SPY_BUBBLE_FILTER_EN
    always_comb begin
        encDepth = '0;
        bubble   = 1'b0;
        for (int k = 0; k < STAGES; k++) encDepth = encDepth + TAP_W'(nVec[k]);
    end
`else
    logic seenZero;
    always_comb begin
        encDepth = '0;
        bubble   = 1'b0;
        seenZero = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (!nVec[k])      seenZero = 1'b1;
            else if (seenZero) bubble   = 1'b1;
            else               encDepth = TAP_W'(k + 1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            depth     <= '0;
            depth_sum <= '0;
            error     <= 1'b0;
            launch    <= 1'b0;
            settleCnt <= '0;
            sampleCnt <= '0;
            tapA      <= '0;
            tapB      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    depth_sum <= '0;
                    error     <= 1'b0;
                    sampleCnt <= '0;
                    settleCnt <= '0;
                    busy      <= 1'b1;
                    state     <= SETTLE;
                end
                SETTLE: begin
                    if (settleCnt == SCW'(SETTLE_CYCLES - 1)) begin
                        settleCnt <= '0;
                        state     <= LAUNCH;
                    end else begin
                        settleCnt <= settleCnt + 1'b1;
                    end
                end
                LAUNCH: begin
                    launch <= ~launch;
                    state  <= CAPTURE;
                end
                // Exactly one clk after the launch edge: this is the measurement window.
                CAPTURE: begin
                    tapA  <= taps;
                    state <= SYNC;
                end
                SYNC: begin
                    tapB  <= tapA;
                    state <= ACCUM;
                end
                ACCUM: begin
                    depth     <= encDepth;
                    depth_sum <= depth_sum + SUM_W'(encDepth);
                    error     <= error | bubble;
                    sampleCnt <= sampleCnt + 1'b1;
                    if (sampleCnt == CNT_W'(LAUNCHES - 1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= SETTLE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spy_chain_sensor.sv
// Bench for spy_chain_sensor: a default-size and a tiny instance, checked every cycle against
// a round-level timing/result model, with tapB forced to synthetic tap patterns on the big one.

module tb_spy_chain_sensor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic startDrv [2];
    always #5 clk = ~clk;

    logic       busy0, done0, err0, busy1, done1, err1;
    logic [5:0] dep0;
    logic [9:0] sum0;
    logic [2:0] dep1, sum1;

    spy_chain_sensor uDut (
        .clk(clk), .rst(rst), .start(startDrv[0]), .busy(busy0), .done(done0),
        .depth(dep0), .depth_sum(sum0), .error(err0)
    );
    spy_chain_sensor #(.STAGES(7), .SETTLE_CYCLES(1), .ACC_LOG2(0)) uSmall (
        .clk(clk), .rst(rst), .start(startDrv[1]), .busy(busy1), .done(done1),
        .depth(dep1), .depth_sum(sum1), .error(err1)
    );

    int checks = 0;
    int errors = 0;
    bit chkOn  = 0;
    int cyc    = 0;

    // Model state per instance
    int stg [2] = '{50, 7};
    int sc  [2] = '{4, 1};
    int nl  [2] = '{16, 1};
    int T   [2] = '{129, 6};
    bit active [2];
    int acceptCyc [2];
    int rd [2];
    bit re [2];
    int hDep [2];
    int hSum [2];
    bit hErr [2];
    bit launchPar [2];

    bit          forceOn = 0;
    logic [49:0] nPat    = '1;
    logic [49:0] fv;

    task automatic chk(input string nm, input int i, input int act, input int exp);
        if (chkOn) begin
            checks++;
            if (act != exp) begin
                errors++;
                $display("FAIL %s dut%0d at cyc %0d: actual=%0d required=%0d", nm, i, cyc, act, exp);
            end
        end
    endtask

    function automatic void enc(input logic [49:0] p, input int w, output int lead, output int pop);
        bit z;
        z = 0; lead = 0; pop = 0;
        for (int k = 0; k < w; k++) begin
            if (p[k]) begin
                pop++;
                if (!z) lead++;
            end else z = 1;
        end
    endfunction

    initial begin
        startDrv[0] = 0;
        startDrv[1] = 0;
        for (int i = 0; i < 2; i++) begin
            active[i] = 0; acceptCyc[i] = 0; hDep[i] = 0; hSum[i] = 0; hErr[i] = 0; launchPar[i] = 0;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Present the chosen n pattern on tapB, re-polarised for the current launch value.
    initial forever begin
        @(negedge clk);
        if (forceOn) begin
            for (int k = 0; k < 50; k++) fv[k] = ~nPat[k] ^ (uDut.launch ^ (k % 2 == 0));
            force uDut.tapB = fv;
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int n, cnt, aDep, aSum, lead, pop;
            logic aBusy, aDone, aErr, aLch;
            logic [49:0] pat;
            aBusy = (i == 0) ? busy0 : busy1;
            aDone = (i == 0) ? done0 : done1;
            aErr  = (i == 0) ? err0 : err1;
            aDep  = (i == 0) ? int'(dep0) : int'(dep1);
            aSum  = (i == 0) ? int'(sum0) : int'(sum1);
            aLch  = (i == 0) ? uDut.launch : uSmall.launch;
            n = cyc - acceptCyc[i];
            if (active[i] && n <= T[i]) begin
                cnt = 0;
                for (int k = 1; k <= nl[i]; k++)
                    if (n >= (k - 1) * (sc[i] + 4) + sc[i] + 2) cnt++;
                chk("busy", i, aBusy, 1);
                chk("done", i, aDone, (n == T[i]) ? 1 : 0);
                chk("launch", i, aLch, launchPar[i] ^ cnt[0]);
                if (n <= sc[i] + 4) begin
                    chk("sumCleared", i, aSum, 0);
                    chk("errCleared", i, aErr, 0);
                    chk("depthHeldIntoRound", i, aDep, hDep[i]);
                end
                if (n == T[i]) begin
                    hDep[i] = rd[i];
                    hSum[i] = rd[i] * nl[i];
                    hErr[i] = re[i];
                    chk("depth", i, aDep, hDep[i]);
                    chk("depth_sum", i, aSum, hSum[i]);
                    chk("error", i, aErr, hErr[i]);
                    launchPar[i] ^= nl[i][0];
                end
            end else begin
                chk("busyIdle", i, aBusy, 0);
                chk("doneIdle", i, aDone, 0);
                chk("depthHeld", i, aDep, hDep[i]);
                chk("sumHeld", i, aSum, hSum[i]);
                chk("errHeld", i, aErr, hErr[i]);
                chk("launchIdle", i, aLch, launchPar[i]);
            end
            // Predict what the coming edge does.
            if (rst) begin
                active[i] = 0; hDep[i] = 0; hSum[i] = 0; hErr[i] = 0; launchPar[i] = 0;
            end else if (startDrv[i] && (!active[i] || n > T[i])) begin
                active[i]    = 1;
                acceptCyc[i] = cyc;
                pat = (i == 0 && forceOn) ? nPat : '1;
                enc(pat, stg[i], lead, pop);
`ifdef SPY_BUBBLE_FILTER_EN
                rd[i] = pop;
                re[i] = 0;
`else
                rd[i] = lead;
                re[i] = (pop != lead);
`endif
            end
        end
    end

    task automatic runRound(input int i, input int spurAt, output int doneAt);
        @(posedge clk); #1;
        startDrv[i] = 1;
        doneAt = -1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            startDrv[i] = (c == spurAt);
            if (((i == 0) ? done0 : done1) === 1'b1) begin
                doneAt = c;
                break;
            end
        end
        startDrv[i] = 0;
        if (doneAt < 0) chk("doneTimeout", i, 0, 1);
    endtask

    initial begin
        int d;
        logic [63:0] r;
        repeat (3) @(posedge clk);
        #1 chkOn = 1;
        @(posedge clk); #1 rst = 0;

        // Tiny instance: two rounds, launch polarity alternates.
        runRound(1, 0, d);
        chk("smallDoneAt", 1, d, 6);
        chk("smallDepth", 1, int'(dep1), 7);
        chk("smallSum", 1, int'(sum1), 7);
        chk("smallLaunch1", 1, int'(uSmall.launch), 1);
        runRound(1, 0, d);
        chk("smallLaunch2", 1, int'(uSmall.launch), 0);

        // Nominal zero-delay round with a start pulse mid-round.
        runRound(0, 50, d);
        chk("nomDoneAt", 0, d, 129);
        chk("nomDepth", 0, int'(dep0), 50);
        chk("nomSum", 0, int'(sum0), 800);
        chk("nomErr", 0, int'(err0), 0);
        repeat (3) @(posedge clk);

        // Forced: 20 leading ones.
        nPat = 50'h00000000FFFFF;
        forceOn = 1;
        runRound(0, 0, d);
        chk("th20Depth", 0, int'(dep0), 20);
        chk("th20Sum", 0, int'(sum0), 320);
        chk("th20Err", 0, int'(err0), 0);

        // Forced: ones at 0..9 plus a bubble at 15.
        nPat = 50'h00000000083FF;
        runRound(0, 0, d);
`ifdef SPY_BUBBLE_FILTER_EN
        chk("bubDepth", 0, int'(dep0), 11);
        chk("bubErr", 0, int'(err0), 0);
`else
        chk("bubDepth", 0, int'(dep0), 10);
        chk("bubErr", 0, int'(err0), 1);
`endif
        forceOn = 0;
        release uDut.tapB;

        // Reset at cycle 40 of a round, then a clean round.
        @(posedge clk); #1 startDrv[0] = 1;
        @(posedge clk); #1 startDrv[0] = 0;
        repeat (39) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        chk("rstBusy", 0, int'(busy0), 0);
        chk("rstSum", 0, int'(sum0), 0);
        chk("rstLaunch", 0, int'(uDut.launch), 0);
        runRound(0, 0, d);
        chk("postRstDoneAt", 0, d, 129);
        chk("postRstDepth", 0, int'(dep0), 50);

        // Randomised traffic: random starts, rare resets, random tap patterns.
        forceOn = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            startDrv[0] = ($urandom_range(0, 19) == 0);
            startDrv[1] = ($urandom_range(0, 9) == 0);
            rst         = ($urandom_range(0, 799) == 0);
            if (!active[0] || (cyc - acceptCyc[0]) > T[0]) begin
                case ($urandom_range(0, 2))
                    0: nPat = '1;
                    1: begin
                        r = ~64'd0;
                        nPat = 50'(r >> (64 - $urandom_range(0, 50)));
                    end
                    default: begin
                        r = {$urandom, $urandom};
                        nPat = r[49:0];
                    end
                endcase
            end
        end
        startDrv[0] = 0;
        startDrv[1] = 0;
        rst = 0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spy_chain_sensor.md
# spy_chain_sensor

Parametrised delay-chain sensor for the hardware-delay spy. It builds a configurable-length chain of inverting path cells and launches an edge into it from a register. It captures all chain taps exactly one clock period later, then converts the thermometer pattern to a propagation depth. Depth is accumulated over 2^ACC_LOG2 launches and published with a done pulse, for use by the readout/logging logic.

## Interface

Parameters:
- STAGES, 50: number of chained inverting stages; legal range 2..1024.
- SETTLE_CYCLES, 4: idle cycles before each launch so the chain settles; legal range ≥1.
- ACC_LOG2, 4: log2 of launches per measurement round; legal range 0..8.
- TAP_W, $clog2(STAGES+1): derived local parameter, not overridable.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one measurement round. Sampled only in IDLE.
- busy  out  1  high while a round is in progress.
- done  out  1  one-cycle pulse when the round result is valid.
- depth  out  TAP_W  depth of the last launch in the round.
- depth_sum  out  TAP_W+ACC_LOG2  sum of depths over the round.
- error  out  1  bubble seen in any launch of the round.

## Operation

- Chain:
  - Stage k is a `singlepath_1_spy_p1n` with side inputs tied 0,0,1,0, which makes it an inverter.
  - Stage 0 is driven by `launch`; its output is `taps[k]`.
  - All tap nets carry (* keep = 1 *).
- `launch` register:
  - Reset value 0.
  - Toggles once per launch, so rising and falling edges alternate.
- Normalisation:
  - Expected settled value of tap k: e[k] = launch ^ (k even).
  - n[k] = ~(tap_b[k] ^ e[k]), i.e. 1 means the edge has reached stage k.
- Encoding:
  - depth = number of contiguous ones in n starting from k=0.
  - A bubble is any n[j]=1 above the first n[i]=0 (i<j); a bubble sets error.
- FSM states: IDLE, SETTLE, LAUNCH, CAPTURE, SYNC, ACCUM, DONE.
  - IDLE: when start=1, clear depth_sum, error and the sample counter, then go to SETTLE.
  - SETTLE: hold for SETTLE_CYCLES cycles, then go to LAUNCH.
  - LAUNCH: toggle `launch` on exit.
  - CAPTURE: tap_a <= taps on exit.
  - SYNC: tap_b <= tap_a.
  - ACCUM: depth <= encode(tap_b); depth_sum += depth; error |= bubble. Then go to DONE if this was launch 2^ACC_LOG2, else to SETTLE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Arithmetic: depth_sum is sized so it cannot overflow (STAGES·2^ACC_LOG2 fits).
- start while busy: ignored, no queuing.
- Outputs depth, depth_sum and error hold their values after DONE until the next accepted start.

## Timing

- Reset values: busy 0, done 0, depth 0, depth_sum 0, error 0, launch 0, state IDLE.
- Reset mid-round: round is abandoned; all of the above apply on the cycle after rst is sampled high.
- busy goes high the cycle after start is accepted. It stays high through DONE and drops in the cycle after done.
- Each launch takes SETTLE_CYCLES+4 cycles.
- done is high in cycle 1 + 2^ACC_LOG2·(SETTLE_CYCLES+4) after the accepting edge. With defaults this is cycle 129.
- Measurement window is exactly one clk period: launch toggles at edge E, taps are captured at edge E+1.
- tap_a may go metastable. tap_b is the second flop and is the only tap register the encoder reads.
- start may be asserted in the same cycle as done. It is not accepted until the FSM is back in IDLE, i.e. the next cycle.

## Configuration

- SPY_BUBBLE_FILTER_EN:
  - Defined: depth = popcount(n), which tolerates bubbles; error is tied to 0.
  - Undefined: depth is leading-ones as above, and error reports bubbles.

## Test plan

- Zero-delay sim, defaults, start pulse:
  - done at cycle 129; depth=50, depth_sum=800, error=0.
  - busy high from cycle 1 to cycle 129.
- Force tap_b so n = 20 ones then 30 zeros on every launch, ACC_LOG2=2 → depth=20, depth_sum=80, error=0.
- Force n = ones at k=0..9 and k=15, zeros elsewhere:
  - Without macro: depth=10, error=1.
  - With SPY_BUBBLE_FILTER_EN: depth=11, error=0.
- Pulse start again at cycle 50 of a round → ignored; round still completes at cycle 129 with a single done pulse.
- Assert rst at cycle 40 → next cycle busy=0, depth_sum=0, launch=0. A new start then completes normally at cycle 129 relative to that start.
- STAGES=7, SETTLE_CYCLES=1, ACC_LOG2=0:
  - done at cycle 6; depth=7, depth_sum=7.
  - launch toggles once per round (check polarity alternation over two rounds).
